// File: rtl/uart.sv
// uart: memory-mapped 8N1 UART with programmable baud divisor and internal TX->RX loopback
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   en               hold: parks both FSMs and baud counters in idle, register access still works
//   addr, re, we     2-bit register bus: 00 TX data / status, 01 RX data, 10 divisor, 11 zero
//   wdata, rdata     write data, registered read data
//   tx               serial line (idle high), also the receiver input
//   tx_busy          a frame is in progress
//   rx_valid         an unread received byte is held
module uart (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] addr,
  input  logic       re,
  input  logic       we,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       tx,
  output logic       tx_busy,
  output logic       rx_valid
);
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
  state_t     r_tx_st, r_rx_st;
  logic [7:0] r_div, r_tx_sh, r_tx_cnt, r_rx_sh, r_rx_cnt, r_rx_data;
  logic [2:0] r_tx_bit, r_rx_bit;
  logic       r_tx, r_rx_prev, r_rx_valid;
  logic [7:0] w_div, w_half;
  logic       w_tx_end, w_rx_end, w_rx_chk, w_tx_go, w_rx_done;
  assign w_div     = (r_div < 8'd2) ? 8'd1 : r_div;
  assign w_half    = w_div >> 1;
  assign w_tx_end  = r_tx_cnt >= w_div - 8'd1;
  assign w_rx_end  = r_rx_cnt >= w_div - 8'd1;
  // START is entered one cycle after tx falls, so +2 lands the re-check DIV/2 cycles after the edge
  assign w_rx_chk  = ({1'b0, r_rx_cnt} + 9'd2) >= {1'b0, w_half};
  assign w_tx_go   = we && addr == 2'b00 && !en && r_tx_st == S_IDLE;
  assign w_rx_done = !en && r_rx_st == S_STOP && w_rx_end && r_tx;
  assign tx        = r_tx;
  assign tx_busy   = r_tx_st != S_IDLE;
  assign rx_valid  = r_rx_valid;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div      <= 8'd16;
      rdata      <= 8'd0;
      r_rx_valid <= 1'b0;
    end else begin
      if (we && addr == 2'b10) r_div <= wdata;
      if (re) rdata <= addr == 2'b00 ? {6'b0, r_rx_valid, tx_busy} :
                       addr == 2'b01 ? r_rx_data :
                       addr == 2'b10 ? r_div : 8'd0;
      // a completing byte wins over a same-cycle clearing read
      if (w_rx_done) r_rx_valid <= 1'b1;
      else if (re && addr == 2'b01) r_rx_valid <= 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_st  <= S_IDLE;
      r_tx     <= 1'b1;
      r_tx_cnt <= 8'd0;
      r_tx_bit <= 3'd0;
      r_tx_sh  <= 8'd0;
    end else if (en) begin
      r_tx_st  <= S_IDLE;
      r_tx     <= 1'b1;
      r_tx_cnt <= 8'd0;
    end else begin
      r_tx_cnt <= (r_tx_st == S_IDLE || w_tx_end) ? 8'd0 : r_tx_cnt + 8'd1;
      case (r_tx_st)
        S_IDLE: if (w_tx_go) begin
          r_tx_sh <= wdata;
          r_tx_st <= S_START;
          r_tx    <= 1'b0;
        end
        S_START: if (w_tx_end) begin
          r_tx     <= r_tx_sh[0];
          r_tx_bit <= 3'd0;
          r_tx_st  <= S_DATA;
        end
        S_DATA: if (w_tx_end) begin
          r_tx_sh  <= {1'b0, r_tx_sh[7:1]};
          r_tx_bit <= r_tx_bit + 3'd1;
          r_tx     <= r_tx_bit == 3'd7 ? 1'b1 : r_tx_sh[1];
          r_tx_st  <= r_tx_bit == 3'd7 ? S_STOP : S_DATA;
        end
        S_STOP: if (w_tx_end) r_tx_st <= S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_st   <= S_IDLE;
      r_rx_cnt  <= 8'd0;
      r_rx_bit  <= 3'd0;
      r_rx_sh   <= 8'd0;
      r_rx_data <= 8'd0;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_prev <= r_tx;
      if (en) begin
        r_rx_st  <= S_IDLE;
        r_rx_cnt <= 8'd0;
      end else begin
        case (r_rx_st)
          S_IDLE: begin
            r_rx_cnt <= 8'd0;
            if (r_rx_prev && !r_tx) r_rx_st <= S_START;
          end
          S_START: begin
            r_rx_cnt <= w_rx_chk ? 8'd0 : r_rx_cnt + 8'd1;
            r_rx_bit <= 3'd0;
            if (w_rx_chk) r_rx_st <= r_tx ? S_IDLE : S_DATA;
          end
          S_DATA: begin
            r_rx_cnt <= w_rx_end ? 8'd0 : r_rx_cnt + 8'd1;
            if (w_rx_end) begin
              r_rx_sh  <= {r_tx, r_rx_sh[7:1]};
              r_rx_bit <= r_rx_bit + 3'd1;
              if (r_rx_bit == 3'd7) r_rx_st <= S_STOP;
            end
          end
          S_STOP: begin
            r_rx_cnt <= w_rx_end ? 8'd0 : r_rx_cnt + 8'd1;
            if (w_rx_end) begin
              r_rx_st <= S_IDLE;
              if (r_tx) r_rx_data <= r_rx_sh;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart.sv
// tb_uart: directed self-checking bench for the loopback uart
module tb_uart;
  logic       clk = 1'b0, rst = 1'b1, en = 1'b0, re = 1'b0, we = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [7:0] wdata = 8'd0, rdata, d;
  logic       tx, tx_busy, rx_valid;
  logic [9:0] frame;
  int         n_vec = 0, n_err = 0, t_busy, t_rv, t;
  uart dut (.clk(clk), .rst(rst), .en(en), .addr(addr), .re(re), .we(we), .wdata(wdata),
            .rdata(rdata), .tx(tx), .tx_busy(tx_busy), .rx_valid(rx_valid));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask
  task automatic wr(input logic [1:0] a, input logic [7:0] v);
    we = 1'b1; addr = a; wdata = v;
    @(negedge clk);
    we = 1'b0;
  endtask
  task automatic rd(input logic [1:0] a, output logic [7:0] v);
    re = 1'b1; addr = a;
    @(negedge clk);
    re = 1'b0;
    v = rdata;
  endtask
  task automatic wait_rv(output int c);
    c = -1;
    for (int i = 0; i < 3000; i++) begin
      if (rx_valid) begin c = i; break; end
      @(negedge clk);
    end
  endtask
  task automatic wait_idle(output int c);
    c = -1;
    for (int i = 0; i < 3000; i++) begin
      if (!tx_busy) begin c = i; break; end
      @(negedge clk);
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_rxv", rx_valid, 0);
    chk("rst_rdata", rdata, 0);
    rst = 1'b0;
    @(negedge clk);
    rd(2'b10, d); chk("rst_div", d, 16);
    wr(2'b10, 8'd130);
    rd(2'b10, d); chk("div_wr", d, 130);
    frame = {1'b1, 8'hAB, 1'b0};
    wr(2'b00, 8'hAB);
    chk("start_tx", tx, 0);
    chk("start_busy", tx_busy, 1);
    t_busy = -1; t_rv = -1;
    for (int c = 0; c < 1400; c++) begin
      if (c < 1300 && c % 130 == 65) chk($sformatf("frame_bit%0d", c / 130), tx, frame[c / 130]);
      if (t_busy < 0 && !tx_busy) t_busy = c;
      if (t_rv < 0 && rx_valid) t_rv = c;
      if (c == 300) begin we = 1'b1; addr = 2'b00; wdata = 8'h55; end
      else we = 1'b0;
      @(negedge clk);
    end
    chk("busy_len", t_busy, 1300);
    chk("rxv_time", (t_rv >= 1234 && t_rv <= 1236) ? t_rv : -1, t_rv >= 1234 ? t_rv : 1235);
    rd(2'b00, d); chk("status_rxv", d, 8'h02);
    wr(2'b00, 8'h3C);
    repeat (200) @(negedge clk);
    chk("hold_pre_tx", tx, 0);
    en = 1'b1;
    @(negedge clk);
    chk("hold_tx", tx, 1);
    chk("hold_busy", tx_busy, 0);
    chk("hold_rxv", rx_valid, 1);
    wr(2'b00, 8'h77);
    repeat (3) @(negedge clk);
    chk("hold_wr_busy", tx_busy, 0);
    chk("hold_wr_tx", tx, 1);
    en = 1'b0;
    repeat (1400) @(negedge clk);
    chk("hold_after_rxv", rx_valid, 1);
    rd(2'b01, d); chk("rx_ab", d, 8'hAB);
    chk("rxv_clr", rx_valid, 0);
    rd(2'b00, d); chk("status_idle", d, 0);
    wr(2'b10, 8'd16);
    wr(2'b00, 8'h00);
    wait_rv(t); chk("b2b0_rv_t", (t >= 151 && t <= 153) ? 152 : t, 152);
    rd(2'b01, d); chk("b2b0_data", d, 8'h00);
    chk("b2b0_clr", rx_valid, 0);
    wait_idle(t); chk("b2b0_idle", t >= 0, 1);
    wr(2'b00, 8'hFF);
    chk("b2b1_busy", tx_busy, 1);
    wait_rv(t); chk("b2b1_rv", t >= 0, 1);
    rd(2'b01, d); chk("b2b1_data", d, 8'hFF);
    chk("b2b1_clr", rx_valid, 0);
    wait_idle(t);
    wr(2'b00, 8'hF0);
    repeat (20) @(negedge clk);
    rd(2'b10, d); chk("pre_rst_div", d, 16);
    chk("pre_rst_tx", tx, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_tx", tx, 1);
    chk("arst_busy", tx_busy, 0);
    chk("arst_rdata", rdata, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_rxv", rx_valid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
